// File: rtl/tmds_decoder_pkg.sv
// Shared types and constants for the TMDS channel decoder.
package tmds_decoder_pkg;

    // One 10-bit TMDS character as it sits on the wire.
    typedef logic [9:0] tmds_word_t;

    // Control-period characters, indexed by their {c1,c0} value.
    localparam tmds_word_t TokenCtrl00 = 10'h354;
    localparam tmds_word_t TokenCtrl01 = 10'h0AB;
    localparam tmds_word_t TokenCtrl10 = 10'h154;
    localparam tmds_word_t TokenCtrl11 = 10'h2AB;

    // Word-alignment state machine.
    typedef enum logic [1:0] {
        StSearch,
        StVerify,
        StLocked
    } align_state_t;

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational TMDS character decoder: control-token match plus 10b->8b data decode.
module tmds_symbol_decode
    import tmds_decoder_pkg::*;
(
    input  tmds_word_t word_i,
    output logic       is_ctrl_o,
    output logic [1:0] ctrl_o,
    output logic [7:0] data_o
);

    logic [7:0] q;

    // Control tokens are recognised only on an exact match
    always_comb begin
        is_ctrl_o = 1'b1;
        ctrl_o    = 2'b00;
        case (word_i)
            TokenCtrl00: ctrl_o = 2'b00;
            TokenCtrl01: ctrl_o = 2'b01;
            TokenCtrl10: ctrl_o = 2'b10;
            TokenCtrl11: ctrl_o = 2'b11;
            default:     is_ctrl_o = 1'b0;
        endcase
    end

    // Undo the optional inversion (bit 9), then the XOR/XNOR chain (bit 8)
    always_comb begin
        q         = word_i[9] ? ~word_i[7:0] : word_i[7:0];
        data_o    = 8'h00;
        data_o[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            data_o[i] = word_i[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
    end

endmodule

// File: rtl/tmds_decoder.sv
// Single-channel TMDS decoder: bit alignment from control-token runs, then character decode.
// Fixed 4-clock latency: d1, d2, aligned word, output register.
module tmds_decoder
    import tmds_decoder_pkg::*;
#(
    parameter int unsigned CTRL_RUN       = 8,
    parameter int unsigned SEARCH_TIMEOUT = 2048,
    parameter int unsigned LOCK_TIMEOUT   = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] raw_in,
    output logic [7:0] data_out,
    output logic [1:0] ctrl_out,
    output logic       de,
    output logic       locked,
    output logic [3:0] offset
);

    localparam int unsigned MaxTimeout =
        (SEARCH_TIMEOUT > LOCK_TIMEOUT) ? SEARCH_TIMEOUT : LOCK_TIMEOUT;
    localparam int unsigned CntW = $clog2(MaxTimeout + 1);
    localparam int unsigned RunW = $clog2(CTRL_RUN + 1);

    localparam logic [CntW-1:0] SearchLimit = CntW'(SEARCH_TIMEOUT);
    localparam logic [CntW-1:0] LockLimit   = CntW'(LOCK_TIMEOUT);
    localparam logic [RunW-1:0] RunLimit    = RunW'(CTRL_RUN);
    localparam logic [RunW-1:0] RunOne      = RunW'(1);
    // Words still in flight under the old offset when the offset moves
    localparam logic [1:0]      SettleWords = 2'd2;

    tmds_word_t   d1_q, d2_q, aligned_q, aligned_d;
    logic [19:0]  window;
    align_state_t state_q;
    logic [3:0]   offset_q, offset_next;
    logic [CntW-1:0] cnt_q, cnt_inc;
    logic [RunW-1:0] run_q, run_inc;
    logic [1:0]   settle_q;
    logic         sym_is_ctrl;
    logic [1:0]   sym_ctrl;
    logic [7:0]   sym_data;

    assign window      = {d1_q, d2_q};
    assign aligned_d   = 10'(window >> offset_q);
    assign offset_next = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
    assign cnt_inc     = (cnt_q == {CntW{1'b1}}) ? cnt_q : cnt_q + CntW'(1);
    assign run_inc     = (run_q == {RunW{1'b1}}) ? run_q : run_q + RunW'(1);
    assign offset      = offset_q;

    tmds_symbol_decode u_symbol_decode (
        .word_i    (aligned_q),
        .is_ctrl_o (sym_is_ctrl),
        .ctrl_o    (sym_ctrl),
        .data_o    (sym_data)
    );

    // History registers and the registered aligned word
    always_ff @(posedge clk) begin
        if (rst) begin
            d1_q      <= '0;
            d2_q      <= '0;
            aligned_q <= '0;
        end else begin
            d1_q      <= raw_in;
            d2_q      <= d1_q;
            aligned_q <= aligned_d;
        end
    end

    // Decoded outputs update in every state; ctrl_out holds through video periods
    always_ff @(posedge clk) begin
        if (rst) begin
            de       <= 1'b0;
            ctrl_out <= 2'b00;
            data_out <= 8'h00;
        end else if (sym_is_ctrl) begin
            de       <= 1'b0;
            ctrl_out <= sym_ctrl;
            data_out <= 8'h00;
        end else begin
            de       <= 1'b1;
            data_out <= sym_data;
        end
    end

    // Alignment FSM: hunt offsets until a run of control tokens holds, then watch for loss
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StSearch;
            offset_q <= 4'd0;
            cnt_q    <= '0;
            run_q    <= '0;
            settle_q <= 2'd0;
            locked   <= 1'b0;
        end else if (settle_q != 2'd0) begin
            settle_q <= settle_q - 2'd1;
        end else begin
            unique case (state_q)
                StSearch: begin
                    if (sym_is_ctrl) begin
                        cnt_q <= '0;
                        run_q <= RunOne;
                        if (RunOne >= RunLimit) begin
                            state_q <= StLocked;
                            locked  <= 1'b1;
                        end else begin
                            state_q <= StVerify;
                        end
                    end else if (cnt_inc >= SearchLimit) begin
                        cnt_q    <= '0;
                        offset_q <= offset_next;
                        settle_q <= SettleWords;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                StVerify: begin
                    if (sym_is_ctrl) begin
                        run_q <= run_inc;
                        if (run_inc >= RunLimit) begin
                            state_q <= StLocked;
                            locked  <= 1'b1;
                            cnt_q   <= '0;
                        end
                    end else begin
                        state_q  <= StSearch;
                        offset_q <= offset_next;
                        settle_q <= SettleWords;
                        run_q    <= '0;
                        cnt_q    <= '0;
                    end
                end
                StLocked: begin
                    if (sym_is_ctrl) begin
                        cnt_q <= '0;
                    end else if (cnt_inc >= LockLimit) begin
                        state_q <= StSearch;
                        locked  <= 1'b0;
                        cnt_q   <= '0;
                        run_q   <= '0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: begin
                    state_q <= StSearch;
                    locked  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tmds_decoder.sv
// Self-checking bench for tmds_decoder: wire-stream model with random data and alignment scenarios.
module tb_tmds_decoder;

    localparam int unsigned CtrlRun  = 8;
    localparam int unsigned SearchTo = 64;
    localparam int unsigned LockTo   = 128;
    localparam logic [9:0]  Tok00    = 10'h354;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] raw_in = '0;
    logic [7:0] data_out;
    logic [1:0] ctrl_out;
    logic       de;
    logic       locked;
    logic [3:0] offset;

    tmds_decoder #(
        .CTRL_RUN       (CtrlRun),
        .SEARCH_TIMEOUT (SearchTo),
        .LOCK_TIMEOUT   (LockTo)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .raw_in   (raw_in),
        .data_out (data_out),
        .ctrl_out (ctrl_out),
        .de       (de),
        .locked   (locked),
        .offset   (offset)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Every raw word driven since the last reset, in wire order
    logic [9:0] hist[$];
    bit         model_en   = 1'b0;
    int         model_off  = 0;
    logic [1:0] model_ctrl = 2'b00;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Raw word carrying character w when the word boundary sits off bits into the stream
    function automatic logic [9:0] place(input logic [9:0] w, input int off);
        logic [19:0] two;
        two = {w, w};
        return 10'(two >> (10 - off));
    endfunction

    // Character starting at bit 'off' of raw word k in the serial stream
    function automatic logic [9:0] stream_word(input int k, input int off);
        logic [19:0] two;
        two = {hist[k+1], hist[k]};
        return 10'(two >> off);
    endfunction

    function automatic bit ref_is_token(input logic [9:0] w, output logic [1:0] val);
        val = 2'b00;
        case (w)
            10'h354: begin val = 2'b00; return 1'b1; end
            10'h0AB: begin val = 2'b01; return 1'b1; end
            10'h154: begin val = 2'b10; return 1'b1; end
            10'h2AB: begin val = 2'b11; return 1'b1; end
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] ref_decode(input logic [9:0] w);
        logic [7:0] q, d;
        q    = w[9] ? ~w[7:0] : w[7:0];
        d    = 8'h00;
        d[0] = q[0];
        for (int i = 1; i < 8; i++) d[i] = w[8] ? (q[i] ^ q[i-1]) : !(q[i] ^ q[i-1]);
        return d;
    endfunction

    // Drive one word, sample after the edge, compare with the stream model when enabled
    task automatic step(input logic [9:0] w);
        logic [9:0]  q;
        logic [1:0]  tv;
        logic [10:0] exp_out;
        @(negedge clk);
        raw_in = w;
        hist.push_back(w);
        @(posedge clk);
        #1;
        if (model_en && hist.size() >= 4) begin
            q = stream_word(hist.size() - 4, model_off);
            if (ref_is_token(q, tv)) begin
                model_ctrl = tv;
                exp_out    = {1'b0, tv, 8'h00};
            end else begin
                exp_out = {1'b1, model_ctrl, ref_decode(q)};
            end
            check_eq("out", 32'({de, ctrl_out, data_out}), 32'(exp_out));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        raw_in = '0;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        model_en = 1'b0;
        hist.delete();
    endtask

    function automatic logic [9:0] rand_data();
        logic [9:0] w;
        logic [1:0] tv;
        do w = 10'($urandom_range(0, 1023)); while (ref_is_token(w, tv));
        return w;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         bad;
        bit         flag;
        logic [3:0] prev;
        logic [9:0] seq[5];

        // Reset state
        do_reset();
        check_eq("rst_locked", 32'(locked), 32'd0);
        check_eq("rst_offset", 32'(offset), 32'd0);
        check_eq("rst_de", 32'(de), 32'd0);
        check_eq("rst_data", 32'(data_out), 32'd0);
        check_eq("rst_ctrl", 32'(ctrl_out), 32'd0);

        // Continuous 0x354 at offset 0: lock exactly CTRL_RUN tokens after the 3-word fill
        for (int c = 1; c <= int'(CtrlRun) + 3; c++) begin
            step(Tok00);
            if (c == int'(CtrlRun) + 2) check_eq("lock0_early", 32'(locked), 32'd0);
            if (c == int'(CtrlRun) + 3) begin
                check_eq("lock0_locked", 32'(locked), 32'd1);
                check_eq("lock0_offset", 32'(offset), 32'd0);
                check_eq("lock0_de", 32'(de), 32'd0);
                check_eq("lock0_ctrl", 32'(ctrl_out), 32'd0);
            end
        end

        // Data words 0x100 and 0x2FF appear exactly 4 clocks after being driven
        model_en   = 1'b1;
        model_off  = 0;
        model_ctrl = 2'b00;
        seq = '{10'h100, 10'h2FF, Tok00, Tok00, Tok00};
        for (int j = 0; j < 5; j++) begin
            step(seq[j]);
            if (j == 2) check_eq("data_not_early", 32'(de), 32'd0);
            if (j == 3) check_eq("data_100", 32'({de, data_out}), 32'h100);
            if (j == 4) check_eq("data_2ff", 32'({de, data_out}), 32'h1FE);
        end

        // Random characters with periodic random tokens, offset 0
        for (int j = 0; j < 48; j++) begin
            if (j % 8 == 7) step(place(10'($urandom_range(0, 3) == 0 ? 10'h0AB : 10'h154), 0));
            else step(10'($urandom_range(0, 1023)));
        end
        for (int j = 0; j < 4; j++) step(Tok00);

        // LOCK_TIMEOUT data words without a token drop the lock, offset kept
        for (int j = 0; j <= int'(LockTo) + 2; j++) begin
            step(rand_data());
            if (j == int'(LockTo) + 1) check_eq("lto_still_locked", 32'(locked), 32'd1);
            if (j == int'(LockTo) + 2) begin
                check_eq("lto_unlocked", 32'(locked), 32'd0);
                check_eq("lto_offset", 32'(offset), 32'd0);
            end
        end
        model_en = 1'b0;

        // SEARCH timeout: offset advances after SEARCH_TIMEOUT words without a token
        do_reset();
        for (int c = 1; c <= int'(SearchTo); c++) begin
            step(10'h000);
            if (c == int'(SearchTo) - 1) check_eq("sto_before", 32'(offset), 32'd0);
            if (c == int'(SearchTo)) check_eq("sto_after", 32'(offset), 32'd1);
        end

        // VERIFY broken by a data word after 4 tokens moves to the next offset
        do_reset();
        for (int c = 1; c <= 8; c++) begin
            step(c <= 4 ? Tok00 : 10'h000);
            if (c == 7) check_eq("vfy_before", 32'(offset), 32'd0);
            if (c == 8) begin
                check_eq("vfy_after", 32'(offset), 32'd1);
                check_eq("vfy_locked", 32'(locked), 32'd0);
            end
        end

        // Climb through search timeouts to offset 9, one step at a time
        prev = 4'd1;
        bad  = 0;
        flag = 1'b0;
        for (int i = 0; i < 10 * (int'(SearchTo) + 2) + 50 && !flag; i++) begin
            step(10'h000);
            if (offset != prev) begin
                if (offset != prev + 4'd1) bad++;
                prev = offset;
            end
            if (offset == 4'd9) flag = 1'b1;
        end
        check_eq("climb_reached_9", 32'(flag), 32'd1);
        check_eq("climb_steps", 32'(bad), 32'd0);

        // At offset 9: 4 aligned tokens then data -> offset wraps to 0
        for (int i = 0; i < 3; i++) step(10'h000);
        for (int i = 0; i < 4; i++) step(place(Tok00, 9));
        flag = 1'b0;
        for (int i = 0; i < 30 && !flag; i++) begin
            step(10'h000);
            if (offset != 4'd9) flag = 1'b1;
        end
        check_eq("wrap_seen", 32'(flag), 32'd1);
        check_eq("wrap_offset", 32'(offset), 32'd0);

        // Stream shifted by 3 bits: lock at offset 3, then stay put
        do_reset();
        flag = 1'b0;
        for (int i = 0; i < 4 * (int'(SearchTo) + 2) + int'(CtrlRun) + 20 && !flag; i++) begin
            step(place(Tok00, 3));
            if (locked) flag = 1'b1;
        end
        check_eq("lock3_locked", 32'(flag), 32'd1);
        check_eq("lock3_offset", 32'(offset), 32'd3);
        bad = 0;
        for (int i = 0; i < 3 * int'(SearchTo); i++) begin
            step(place(Tok00, 3));
            if (offset != 4'd3 || !locked) bad++;
        end
        check_eq("lock3_stable", 32'(bad), 32'd0);

        // Random raw words decoded through the offset-3 window
        model_en   = 1'b1;
        model_off  = 3;
        model_ctrl = 2'b00;
        for (int i = 0; i < 60; i++) step(10'($urandom_range(0, 1023)));
        model_en = 1'b0;

        // Lock at offset 5, show video, then reset
        do_reset();
        flag = 1'b0;
        for (int i = 0; i < 6 * (int'(SearchTo) + 2) + int'(CtrlRun) + 20 && !flag; i++) begin
            step(place(Tok00, 5));
            if (locked) flag = 1'b1;
        end
        check_eq("lock5_locked", 32'(flag), 32'd1);
        check_eq("lock5_offset", 32'(offset), 32'd5);
        for (int i = 0; i < 4; i++) step(place(10'h2FF, 5));
        check_eq("lock5_video", 32'({de, data_out}), 32'h1FE);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst5_locked", 32'(locked), 32'd0);
        check_eq("rst5_offset", 32'(offset), 32'd0);
        check_eq("rst5_de", 32'(de), 32'd0);
        check_eq("rst5_data", 32'(data_out), 32'd0);
        check_eq("rst5_ctrl", 32'(ctrl_out), 32'd0);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
